// File: rtl/rx_phase_pkg.sv
// Shared phase codes, default sizing and the phase type for the receive phase cycler.
// Optional saturation is enabled by defining RX_PHASE_SAT_EN.
package rx_phase_pkg;

   localparam int DEF_N_BITS = 16;
   localparam int DEF_N_PARA = 4;
   localparam int DEF_DEPTH  = 16;

   typedef logic [1:0] phase_t;

   localparam phase_t PH_0   = 2'd0;
   localparam phase_t PH_90  = 2'd1;
   localparam phase_t PH_180 = 2'd2;
   localparam phase_t PH_270 = 2'd3;

endpackage

// File: rtl/rx_quad_rotate_lane.sv
// Combinational quarter-turn rotation of one complex sample lane.
// With RX_PHASE_SAT_EN defined, negating the most negative value saturates and raises sat.
module rx_quad_rotate_lane
   import rx_phase_pkg::*;
#(
   parameter int N_BITS = DEF_N_BITS
) (
   input  logic [N_BITS-1:0] i,
   input  logic [N_BITS-1:0] q,
   input  logic [1:0]        phase,
   output logic [N_BITS-1:0] i_rot,
   output logic [N_BITS-1:0] q_rot
`ifdef RX_PHASE_SAT_EN
   ,
   output logic              sat
`endif
);

   logic [N_BITS-1:0] neg_i;
   logic [N_BITS-1:0] neg_q;

`ifdef RX_PHASE_SAT_EN
   localparam logic [N_BITS-1:0] MIN_VAL = {1'b1, {(N_BITS-1){1'b0}}};
   localparam logic [N_BITS-1:0] MAX_VAL = ~MIN_VAL;

   logic i_min;
   logic q_min;

   assign i_min = (i == MIN_VAL);
   assign q_min = (q == MIN_VAL);
   assign neg_i = i_min ? MAX_VAL : -i;
   assign neg_q = q_min ? MAX_VAL : -q;
`else
   // Plain two's complement: the most negative value maps onto itself.
   assign neg_i = -i;
   assign neg_q = -q;
`endif

   always_comb begin
      i_rot = i;
      q_rot = q;
`ifdef RX_PHASE_SAT_EN
      sat   = 1'b0;
`endif
      case (phase_t'(phase))
         PH_90: begin
            i_rot = neg_q;
            q_rot = i;
`ifdef RX_PHASE_SAT_EN
            sat   = q_min;
`endif
         end
         PH_180: begin
            i_rot = neg_i;
            q_rot = neg_q;
`ifdef RX_PHASE_SAT_EN
            sat   = i_min | q_min;
`endif
         end
         PH_270: begin
            i_rot = q;
            q_rot = neg_i;
`ifdef RX_PHASE_SAT_EN
            sat   = i_min;
`endif
         end
         default: begin
            i_rot = i;
            q_rot = q;
         end
      endcase
   end

endmodule

// File: rtl/rx_phase_cycler.sv
// Table-driven receive phase rotator with per-scan phase cycling and a 2-stage valid pipeline.
// Defining RX_PHASE_SAT_EN enables saturating negation and the sat_flag output.
module rx_phase_cycler
   import rx_phase_pkg::*;
#(
   parameter int N_BITS = DEF_N_BITS,
   parameter int N_PARA = DEF_N_PARA,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_wr_en,
   input  logic [ADDR_W-1:0]        cfg_addr,
   input  logic [1:0]               cfg_data,
   input  logic [ADDR_W-1:0]        cycle_last,
   input  logic                     scan_start,
   input  logic                     cycle_rst,
   input  logic                     in_valid,
   input  logic [N_BITS*N_PARA-1:0] I_in,
   input  logic [N_BITS*N_PARA-1:0] Q_in,
   output logic                     out_valid,
   output logic [N_BITS*N_PARA-1:0] I_out,
   output logic [N_BITS*N_PARA-1:0] Q_out,
   output logic [1:0]               cur_phase,
   output logic [ADDR_W-1:0]        cur_idx
`ifdef RX_PHASE_SAT_EN
   ,
   output logic                     sat_flag
`endif
);

   phase_t                    table_reg [DEPTH];
   logic                      s1_valid_reg;
   logic [N_BITS*N_PARA-1:0]  s1_i_reg;
   logic [N_BITS*N_PARA-1:0]  s1_q_reg;
   phase_t                    s1_phase_reg;
   logic [N_BITS*N_PARA-1:0]  rot_i;
   logic [N_BITS*N_PARA-1:0]  rot_q;

   // Phase table; a same-cycle scan_start read sees the pre-write entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            table_reg[k] <= PH_0;
         end
      end else if (cfg_wr_en) begin
         table_reg[cfg_addr] <= phase_t'(cfg_data);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_phase <= PH_0;
         cur_idx   <= '0;
      end else if (scan_start && cycle_rst) begin
         cur_phase <= table_reg[0];
         cur_idx   <= (cycle_last == '0) ? '0 : ADDR_W'(1);
      end else if (scan_start) begin
         cur_phase <= table_reg[cur_idx];
         // >= so that shrinking cycle_last below cur_idx still wraps cleanly
         cur_idx   <= (cur_idx >= cycle_last) ? '0 : cur_idx + 1'b1;
      end else if (cycle_rst) begin
         cur_idx   <= '0;
      end
   end

   // Stage 1: capture the beat together with the phase in force this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_i_reg     <= '0;
         s1_q_reg     <= '0;
         s1_phase_reg <= PH_0;
      end else begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_i_reg     <= I_in;
            s1_q_reg     <= Q_in;
            s1_phase_reg <= phase_t'(cur_phase);
         end
      end
   end

`ifdef RX_PHASE_SAT_EN
   logic [N_PARA-1:0] lane_sat;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N_PARA; gi++) begin : g_lane
         rx_quad_rotate_lane #(
            .N_BITS (N_BITS)
         ) u_lane (
            .i     (s1_i_reg[gi*N_BITS +: N_BITS]),
            .q     (s1_q_reg[gi*N_BITS +: N_BITS]),
            .phase (s1_phase_reg),
            .i_rot (rot_i[gi*N_BITS +: N_BITS]),
            .q_rot (rot_q[gi*N_BITS +: N_BITS])
`ifdef RX_PHASE_SAT_EN
            ,
            .sat   (lane_sat[gi])
`endif
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         I_out     <= '0;
         Q_out     <= '0;
      end else begin
         out_valid <= s1_valid_reg;
         if (s1_valid_reg) begin
            I_out <= rot_i;
            Q_out <= rot_q;
         end
      end
   end

`ifdef RX_PHASE_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_flag <= 1'b0;
      end else begin
         sat_flag <= s1_valid_reg & (|lane_sat);
      end
   end
`endif

endmodule

// File: tb/tb_rx_phase_cycler.sv
// Directed self-checking bench for rx_phase_cycler (N_BITS=16, N_PARA=4, DEPTH=16).
// Honours RX_PHASE_SAT_EN for the saturation expectations and sat_flag hookup.
module tb_rx_phase_cycler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_wr_en = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [1:0]  cfg_data = '0;
   logic [3:0]  cycle_last = '0;
   logic        scan_start = 1'b0;
   logic        cycle_rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] I_in = '0;
   logic [63:0] Q_in = '0;
   logic        out_valid;
   logic [63:0] I_out;
   logic [63:0] Q_out;
   logic [1:0]  cur_phase;
   logic [3:0]  cur_idx;
`ifdef RX_PHASE_SAT_EN
   logic        sat_flag;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rx_phase_cycler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_wr_en  (cfg_wr_en),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cycle_last (cycle_last),
      .scan_start (scan_start),
      .cycle_rst  (cycle_rst),
      .in_valid   (in_valid),
      .I_in       (I_in),
      .Q_in       (Q_in),
      .out_valid  (out_valid),
      .I_out      (I_out),
      .Q_out      (Q_out),
      .cur_phase  (cur_phase),
      .cur_idx    (cur_idx)
`ifdef RX_PHASE_SAT_EN
      ,
      .sat_flag   (sat_flag)
`endif
   );

   function automatic logic [63:0] rep(input int v);
      logic [15:0] s;
      s = 16'(v);
      return {4{s}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic wr(input int a, input int d);
      cfg_wr_en = 1'b1;
      cfg_addr  = 4'(a);
      cfg_data  = 2'(d);
      tick();
      cfg_wr_en = 1'b0;
   endtask

   task automatic scan(input logic with_rst);
      scan_start = 1'b1;
      cycle_rst  = with_rst;
      tick();
      scan_start = 1'b0;
      cycle_rst  = 1'b0;
   endtask

   // Single beat; returns with the rotated result on the outputs.
   task automatic beat(input logic [63:0] i_v, input logic [63:0] q_v);
      in_valid = 1'b1;
      I_in     = i_v;
      Q_in     = q_v;
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   int exp_ph  [5] = '{1, 2, 3, 0, 1};
   int exp_idx [5] = '{1, 2, 3, 0, 1};
   int exp_i   [5] = '{-2000, -1000, 2000, 1000, -2000};
   int exp_q   [5] = '{1000, -2000, -1000, 2000, 1000};
   logic [63:0] sat_i;

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_ov", 64'(out_valid), 64'd0);
      chk("rst_i", I_out, 64'd0);
      chk("rst_q", Q_out, 64'd0);
      chk("rst_ph", 64'(cur_phase), 64'd0);
      chk("rst_idx", 64'(cur_idx), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Pass-through stream with phase 0, latency 2
      in_valid = 1'b1;
      I_in = rep(100);
      Q_in = rep(-50);
      tick();
      chk("pt_ov_e1", 64'(out_valid), 64'd0);
      tick();
      chk("pt_ov_e2", 64'(out_valid), 64'd1);
      chk("pt_i", I_out, rep(100));
      chk("pt_q", Q_out, rep(-50));
      tick();
      in_valid = 1'b0;
      chk("pt_ov_e3", 64'(out_valid), 64'd1);
      tick();
      chk("pt_ov_e4", 64'(out_valid), 64'd1);
      tick();
      chk("pt_ov_e5", 64'(out_valid), 64'd0);

      // Phase table sequencing with wrap
      wr(0, 1);
      wr(1, 2);
      wr(2, 3);
      wr(3, 0);
      cycle_last = 4'd3;
      for (int k = 0; k < 5; k++) begin
         scan(1'b0);
         chk($sformatf("seq_idx%0d", k), 64'(cur_idx), 64'(exp_idx[k]));
         chk($sformatf("seq_ph%0d", k), 64'(cur_phase), 64'(exp_ph[k]));
         beat(rep(1000), rep(2000));
         chk($sformatf("seq_i%0d", k), I_out, rep(exp_i[k]));
         chk($sformatf("seq_q%0d", k), Q_out, rep(exp_q[k]));
      end

      // Phase alignment around scan_start
      wr(0, 0);
      scan(1'b1);
      chk("al_ph0", 64'(cur_phase), 64'd0);
      chk("al_idx1", 64'(cur_idx), 64'd1);
      wr(0, 2);
      cycle_rst = 1'b1;
      tick();
      cycle_rst = 1'b0;
      chk("crst_idx", 64'(cur_idx), 64'd0);
      chk("crst_ph", 64'(cur_phase), 64'd0);
      in_valid = 1'b1;
      I_in = rep(1000);
      Q_in = rep(2000);
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("al_a_i", I_out, rep(1000));
      chk("al_a_q", Q_out, rep(2000));
      chk("al_ph2", 64'(cur_phase), 64'd2);
      tick();
      chk("al_b_i", I_out, rep(-1000));
      chk("al_b_q", Q_out, rep(-2000));

      // cycle_rst together with scan_start
      scan(1'b0);
      chk("both_pre_idx", 64'(cur_idx), 64'd2);
      wr(0, 3);
      scan(1'b1);
      chk("both_ph", 64'(cur_phase), 64'd3);
      chk("both_idx", 64'(cur_idx), 64'd1);
      cycle_last = 4'd0;
      scan(1'b1);
      chk("both0_ph", 64'(cur_phase), 64'd3);
      chk("both0_idx", 64'(cur_idx), 64'd0);

      // Simultaneous write and read of entry 0 returns the old entry
      cycle_last = 4'd3;
      cfg_wr_en = 1'b1;
      cfg_addr = 4'd0;
      cfg_data = 2'd1;
      scan(1'b0);
      cfg_wr_en = 1'b0;
      chk("rw_old_ph", 64'(cur_phase), 64'd3);
      scan(1'b1);
      chk("rw_new_ph", 64'(cur_phase), 64'd1);

      // Shortened cycle_last while beyond it wraps to 0
      scan(1'b0);
      chk("short_pre", 64'(cur_idx), 64'd2);
      cycle_last = 4'd1;
      scan(1'b0);
      chk("short_ph", 64'(cur_phase), 64'd3);
      chk("short_idx", 64'(cur_idx), 64'd0);

      // Most negative value through 180 degrees
      wr(0, 2);
      scan(1'b1);
      chk("sat_ph", 64'(cur_phase), 64'd2);
      sat_i = {16'd100, 16'd100, 16'd100, 16'h8000};
      beat(sat_i, rep(5));
`ifdef RX_PHASE_SAT_EN
      chk("sat_i", I_out, {16'hff9c, 16'hff9c, 16'hff9c, 16'h7fff});
      chk("sat_flag", 64'(sat_flag), 64'd1);
`else
      chk("wrap_i", I_out, {16'hff9c, 16'hff9c, 16'hff9c, 16'h8000});
`endif
      chk("sat_q", Q_out, rep(-5));

      // Reset with beats in flight
      cycle_last = 4'd3;
      in_valid = 1'b1;
      I_in = rep(300);
      Q_in = rep(400);
      tick();
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_ov", 64'(out_valid), 64'd0);
      chk("mrst_i", I_out, 64'd0);
      chk("mrst_q", Q_out, 64'd0);
      chk("mrst_ph", 64'(cur_phase), 64'd0);
      chk("mrst_idx", 64'(cur_idx), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_ov0", 64'(out_valid), 64'd0);
      in_valid = 1'b1;
      I_in = rep(7);
      Q_in = rep(8);
      tick();
      in_valid = 1'b0;
      chk("post_ov1", 64'(out_valid), 64'd0);
      tick();
      chk("post_ov2", 64'(out_valid), 64'd1);
      chk("post_i", I_out, rep(7));
      chk("post_q", Q_out, rep(8));
      tick();
      chk("post_ov3", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_phase_cycler.md
Name: rx_phase_cycler

Overview:
- Receiver-side quadrature phase rotator with a built-in NMR phase-cycling sequencer.
- Rotates N_PARA parallel complex samples (I+jQ) by 0/90/180/270 deg. The rotation is taken from a programmable phase table that advances one entry per scan.
- Sits between the receive DDC/mixer output and the accumulator/capture path. Replaces the fixed combinational rotator with a pipelined, valid-qualified, table-driven block.

Parameters:
- N_BITS, 16, bits per sample lane (two's complement)
- N_PARA, 4, parallel samples per clock
- DEPTH, 16, phase table entries (power of two, 2..64)
- ADDR_W, $clog2(DEPTH), table index width (derived; not overridden)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr_en  in  1  table write strobe
- cfg_addr  in  ADDR_W  table write address
- cfg_data  in  2  phase code: 0=0, 1=90, 2=180, 3=270 deg
- cycle_last  in  ADDR_W  index of last active table entry (cycle length = cycle_last+1)
- scan_start  in  1  one-cycle pulse; load next table phase
- cycle_rst  in  1  one-cycle pulse; rewind sequencer to entry 0
- in_valid  in  1  input samples valid
- I_in  in  N_BITS*N_PARA  packed I lanes, lane 0 in LSBs
- Q_in  in  N_BITS*N_PARA  packed Q lanes
- out_valid  out  1  output samples valid
- I_out  out  N_BITS*N_PARA  rotated I lanes
- Q_out  out  N_BITS*N_PARA  rotated Q lanes
- cur_phase  out  2  phase code currently applied to new samples
- cur_idx  out  ADDR_W  table index to be loaded by next scan_start

Behaviour:
- Interface: single clock, clk. Reset rst_n is asynchronous and active-low. All state is cleared on assertion; release is used synchronously.
- Reset values:
  - out_valid=0, I_out=0, Q_out=0, cur_phase=0, cur_idx=0.
  - All table entries=0.
  - Pipeline valid bits=0.
- Table: DEPTH x 2-bit registers. Written on cfg_wr_en at clk edge.
  - A write and a scan_start read of the same address in the same cycle: the read returns the OLD entry.
- Sequencer, on scan_start:
  - cur_phase <= table[cur_idx].
  - cur_idx <= (cur_idx >= cycle_last) ? 0 : cur_idx+1.
  - The >= compare means a shortened cycle_last while cur_idx is beyond it wraps to 0 on the next scan.
- cycle_rst alone: cur_idx <= 0; cur_phase unchanged.
- cycle_rst and scan_start together:
  - cur_phase <= table[0].
  - cur_idx <= (cycle_last==0) ? 0 : 1.
- Phase alignment: the sample beat presented in cycle T is tagged with cur_phase as registered before edge T. A beat in the same cycle as scan_start uses the old phase; beats from T+1 use the new phase. The phase tag travels with the data, so no beat is ever rotated by a mixed phase.
- Pipeline, latency 2 cycles:
  - Stage 1 registers I_in, Q_in, the phase tag and in_valid.
  - Stage 2 registers the rotated result and out_valid.
  - in_valid at T gives out_valid at T+2.
  - Data registers load only when valid; out_valid follows in_valid exactly, with no bubbles added.
- Rotation per lane k (phase code p):
  - p=0: I'=I, Q'=Q
  - p=1: I'=-Q, Q'=I
  - p=2: I'=-I, Q'=-Q
  - p=3: I'=Q, Q'=-I
- Arithmetic: output width equals input width. Negation is two's complement at N_BITS.
- Boundary: without saturation, -(-2^(N_BITS-1)) wraps to -2^(N_BITS-1).
- No backpressure: the downstream consumer must accept every out_valid beat.
- Reset mid-stream: in-flight beats are discarded; out_valid drops immediately (asynchronously).

Optional Feature:
- Macro: RX_PHASE_SAT_EN.
- Defined: every negation saturates. -(-2^(N_BITS-1)) gives 2^(N_BITS-1)-1 (e.g. -32768 gives +32767 for N_BITS=16). Also adds output sat_flag (1 bit), registered with out_valid: high if any lane of that beat saturated; reset 0.
- Undefined: wrap behaviour as above; sat_flag port absent.
- Latency is unchanged either way.

Decomposition:
- Package rx_phase_pkg:
  - phase code localparams PH_0=0, PH_90=1, PH_180=2, PH_270=3
  - default N_BITS/N_PARA/DEPTH values
  - a 2-bit phase_t typedef
- Sub-module rx_quad_rotate_lane:
  - combinational single-lane rotation (plus saturation under the macro)
  - parameter N_BITS
  - instantiated N_PARA times in a generate loop
- Sequencer, table and pipeline registers live in the top module.

Test Plan:
- Reset then stream I=100, Q=-50 all lanes, no scan_start -> out after 2 cycles I=100, Q=-50 (phase 0); out_valid=in_valid delayed by 2.
- Write table {1,2,3,0}, cycle_last=3, pulse scan_start x5 with beats I=1000, Q=2000 between pulses -> successive outputs (-2000,1000), (-1000,-2000), (2000,-1000), (1000,2000), then (-2000,1000) again (wrap to entry 0); cur_idx sequence 1,2,3,0,1.
- scan_start in same cycle as beat A, beat B next cycle, table[0]=2 -> A keeps old phase 0, B gets 180 deg; no mixed-phase beat.
- cur_idx=2, assert cycle_rst and scan_start together, cycle_last=3, table[0]=3 -> cur_phase=3, cur_idx=1; repeat with cycle_last=0 -> cur_idx=0.
- Lane with I=-32768, phase 2 -> I_out=-32768 without RX_PHASE_SAT_EN; +32767 and sat_flag=1 with it; other lanes unaffected.
- Assert rst_n low mid-stream with two beats in flight -> out_valid and outputs 0 immediately; after release, first out_valid appears exactly 2 cycles after the first new in_valid, with phase 0 and cur_idx=0.
